// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern engine: pattern modes,
// PONG direction encodings and the two-state control FSM encoding.
package led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_RUN   = 2'd0;
  localparam mode_t MODE_PONG  = 2'd1;
  localparam mode_t MODE_COUNT = 2'd2;
  localparam mode_t MODE_BLINK = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_ACTIVE = 1'b1;

endpackage

// File: rtl/led_pattern_if.sv
// Run-control and LED-output bundle of the pattern engine; the controller
// drives en/mode, the engine drives led_c/step.
interface led_pattern_if
  import led_pkg::*;
#(
  parameter int LED_W = 4
) ();

  logic             en;
  mode_t            mode;
  logic [LED_W-1:0] led_c;
  logic             step;

  modport master (output en, output mode, input led_c, input step);
  modport slave  (input en, input mode, output led_c, output step);

endinterface

// File: rtl/led_tick_gen.sv
// Step prescaler: tick pulses on every TICK_DIV-th enabled clock; the count
// holds (is not cleared) while en is low.
module led_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern.sv
// LED pattern engine top: control FSM, pattern register, PONG direction and
// output polarity. Define LED_PATTERN_ACTIVE_LOW_EN for inverted LED drive.
module led_pattern
  import led_pkg::*;
#(
  parameter int LED_W    = 4,
  parameter int TICK_DIV = 50000
) (
  input  logic          clk,
  input  logic          rst,
  led_pattern_if.slave  bus
);

  logic tick;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .tick (tick)
  );

  logic [LED_W-1:0] pattern_q, pattern_d;
  logic             dir_q, dir_d;
  state_t           state_q, state_d;
  mode_t            cur_mode_q, cur_mode_d;
  logic             step_q, step_d;

  always_comb begin
    pattern_d  = pattern_q;
    dir_d      = dir_q;
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    step_d     = 1'b0;
    if (tick) begin
      step_d = 1'b1;
      // A fresh start or a mode change loads the new mode's seed instead of advancing.
      if (state_q == ST_IDLE || bus.mode != cur_mode_q) begin
        state_d    = ST_ACTIVE;
        cur_mode_d = bus.mode;
        dir_d      = DIR_UP;
        case (bus.mode)
          MODE_RUN:   pattern_d = LED_W'(1);
          MODE_PONG:  pattern_d = LED_W'(1);
          MODE_COUNT: pattern_d = '0;
          MODE_BLINK: pattern_d = '1;
        endcase
      end else begin
        case (cur_mode_q)
          MODE_RUN:   pattern_d = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
          MODE_PONG: begin
            // Flip as the end LED is reached so the ends are lit only once.
            if (dir_q == DIR_UP) begin
              pattern_d = pattern_q << 1;
              if (pattern_q[LED_W-2]) dir_d = DIR_DOWN;
            end else begin
              pattern_d = pattern_q >> 1;
              if (pattern_q[1]) dir_d = DIR_UP;
            end
          end
          MODE_COUNT: pattern_d = pattern_q + LED_W'(1);
          MODE_BLINK: pattern_d = ~pattern_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q  <= '0;
      dir_q      <= DIR_UP;
      state_q    <= ST_IDLE;
      cur_mode_q <= MODE_RUN;
      step_q     <= 1'b0;
    end else begin
      pattern_q  <= pattern_d;
      dir_q      <= dir_d;
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      step_q     <= step_d;
    end
  end

`ifdef LED_PATTERN_ACTIVE_LOW_EN
  assign bus.led_c = ~pattern_q;
`else
  assign bus.led_c = pattern_q;
`endif
  assign bus.step = step_q;

endmodule

// File: tb/tb_led_pattern.sv
// Directed self-checking bench for led_pattern (LED_W=4, TICK_DIV=4); expected
// LED values follow LED_PATTERN_ACTIVE_LOW_EN when it is defined.
module tb_led_pattern;
  import led_pkg::*;

  localparam int LED_W    = 4;
  localparam int TICK_DIV = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [3:0] prev_pat;

  led_pattern_if #(.LED_W(LED_W)) bus ();

  led_pattern #(
    .LED_W    (LED_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] exp_led(input logic [3:0] pat);
`ifdef LED_PATTERN_ACTIVE_LOW_EN
    return ~pat;
`else
    return pat;
`endif
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // edges-1 quiet clocks (step low, LEDs held), then the stepping edge.
  task automatic wait_step(input logic [3:0] pat, input string tag, input int edges);
    for (int i = 0; i < edges - 1; i++) begin
      @(posedge clk); #1;
      check({tag, "_quiet_step"}, {3'b0, bus.step}, 4'b0000);
      check({tag, "_quiet_led"}, bus.led_c, exp_led(prev_pat));
    end
    @(posedge clk); #1;
    check({tag, "_step"}, {3'b0, bus.step}, 4'b0001);
    check({tag, "_led"}, bus.led_c, exp_led(pat));
    $display("[TB] %s: led_c=%b step=%b", tag, bus.led_c, bus.step);
    prev_pat = pat;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    prev_pat = 4'b0000;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.mode = MODE_RUN;

    repeat (2) @(posedge clk);
    #1;
    check("reset_led", bus.led_c, exp_led(4'b0000));
    check("reset_step", {3'b0, bus.step}, 4'b0000);
    check("reset_cnt", {2'b0, dut.u_tick.cnt_q}, 4'b0000);

    // RUN: first step after TICK_DIV edges, then one rotate per TICK_DIV clocks
    @(negedge clk);
    rst    = 1'b0;
    bus.en = 1'b1;
    wait_step(4'b0001, "run0", TICK_DIV);
    wait_step(4'b0010, "run1", TICK_DIV);
    wait_step(4'b0100, "run2", TICK_DIV);
    wait_step(4'b1000, "run3", TICK_DIV);
    wait_step(4'b0001, "run_wrap", TICK_DIV);

    // PONG
    bus.mode = MODE_PONG;
    wait_step(4'b0001, "pong0", TICK_DIV);
    wait_step(4'b0010, "pong1", TICK_DIV);
    wait_step(4'b0100, "pong2", TICK_DIV);
    wait_step(4'b1000, "pong3", TICK_DIV);
    wait_step(4'b0100, "pong4", TICK_DIV);
    wait_step(4'b0010, "pong5", TICK_DIV);
    wait_step(4'b0001, "pong6", TICK_DIV);
    wait_step(4'b0010, "pong7", TICK_DIV);
    wait_step(4'b0100, "pong8", TICK_DIV);
    wait_step(4'b1000, "pong9", TICK_DIV);
    wait_step(4'b0100, "pong10", TICK_DIV);

    // async reset between edges while at 0100 heading down
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_led", bus.led_c, exp_led(4'b0000));
    check("async_rst_step", {3'b0, bus.step}, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    prev_pat = 4'b0000;
    wait_step(4'b0001, "pong_rst0", TICK_DIV);
    wait_step(4'b0010, "pong_rst1", TICK_DIV);

    // COUNT: seed 0, 16 advances through the wrap, then two more
    bus.mode = MODE_COUNT;
    wait_step(4'b0000, "count_load", TICK_DIV);
    for (int v = 1; v <= 16; v++) begin
      wait_step(4'(v), "count", TICK_DIV);
    end
    wait_step(4'b0001, "count_after_wrap", TICK_DIV);
    wait_step(4'b0010, "count_mid", TICK_DIV);

    // BLINK from mid-count: seed, toggle, mode glitch between ticks, toggle
    bus.mode = MODE_BLINK;
    wait_step(4'b1111, "blink_load", TICK_DIV);
    wait_step(4'b0000, "blink_off", TICK_DIV);
    bus.mode = MODE_RUN;
    @(posedge clk); #1;
    check("glitch_step", {3'b0, bus.step}, 4'b0000);
    bus.mode = MODE_BLINK;
    wait_step(4'b1111, "blink_on", TICK_DIV - 1);

    // enable hold at cnt=2 in RUN
    bus.mode = MODE_RUN;
    wait_step(4'b0001, "run_reload", TICK_DIV);
    repeat (2) @(posedge clk);
    #1;
    check("hold_cnt_before", {2'b0, dut.u_tick.cnt_q}, 4'b0010);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_led", bus.led_c, exp_led(4'b0001));
      check("hold_step", {3'b0, bus.step}, 4'b0000);
      check("hold_cnt", {2'b0, dut.u_tick.cnt_q}, 4'b0010);
    end
    bus.en = 1'b1;
    wait_step(4'b0010, "en_resume", 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
